// File: rtl/warp_scheduler_pkg.sv
// Shared types and constants for the warp scheduler and its FIFO.
package warp_scheduler_pkg;

   localparam int unsigned THREAD_COUNT = 8;
   localparam int unsigned TC_W         = $clog2(THREAD_COUNT + 1);
   localparam int unsigned WID_W        = 4;
   localparam int unsigned PC_W         = 32;

   localparam logic [WID_W-1:0] NO_WARP = 4'hF;

   typedef struct packed {
      logic [WID_W-1:0] warp_id;
      logic [PC_W-1:0]  start_pc;
      logic [TC_W-1:0]  thread_count;
   } kernel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } core_state_e;

   // Clamp a descriptor's thread count to what a core can run.
   function automatic kernel_t saturate_tc(kernel_t k);
      kernel_t r;
      r = k;
      if (k.thread_count > TC_W'(THREAD_COUNT)) r.thread_count = TC_W'(THREAD_COUNT);
      return r;
   endfunction

endpackage

// File: rtl/warp_scheduler_if.sv
// Host launch and core-array signals of the warp scheduler.
interface warp_scheduler_if
   import warp_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CORES = 2
) ();

   logic                           submit_valid;
   kernel_t                        submit_kernel;
   logic                           submit_ready;
   kernel_t [NUM_CORES-1:0]        core_kernel_out;
   logic [NUM_CORES-1:0]           core_clear;
   logic [NUM_CORES-1:0]           core_finished_in;
   logic [NUM_CORES-1:0][WID_W-1:0] core_finished_warp_id_in;
   logic                           done_valid;
   logic [WID_W-1:0]               done_warp_id;
   logic                           err_zero;
   logic                           all_idle;

   modport master (
      output submit_valid, submit_kernel, core_finished_in, core_finished_warp_id_in,
      input  submit_ready, core_kernel_out, core_clear, done_valid, done_warp_id,
             err_zero, all_idle
   );

   modport slave (
      input  submit_valid, submit_kernel, core_finished_in, core_finished_warp_id_in,
      output submit_ready, core_kernel_out, core_clear, done_valid, done_warp_id,
             err_zero, all_idle
   );

endinterface

// File: rtl/kernel_fifo.sv
// Show-ahead synchronous FIFO of warp descriptors.
module kernel_fifo
   import warp_scheduler_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    wr_en,
   input  kernel_t wr_data,
   input  logic    rd_en,
   output kernel_t rd_data,
   output logic    full,
   output logic    empty
);

   kernel_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally; count tracks simultaneous push/pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/warp_scheduler.sv
// Queues warp descriptors and dispatches/retires them across a core array.
module warp_scheduler
   import warp_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CORES   = 2,
   parameter int unsigned QUEUE_DEPTH = 8
) (
   input logic              clk,
   input logic              rst,
   warp_scheduler_if.slave  bus
);

   localparam int unsigned RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   core_state_e             state_q [NUM_CORES];
   core_state_e             state_d [NUM_CORES];
   kernel_t [NUM_CORES-1:0] kernel_q, kernel_d;
   logic [NUM_CORES-1:0]    clear_q, clear_d;
   logic [NUM_CORES-1:0]    grant_vec, retire_vec;
   logic [RR_W-1:0]         rr_q, rr_d;
   logic                    done_valid_q, done_valid_d;
   logic [WID_W-1:0]        done_id_q, done_id_d;
   logic                    err_q;
   logic                    cores_idle;

   logic    fifo_full, fifo_empty, fifo_wr, fifo_rd;
   kernel_t fifo_rdata;
   logic    submit_acc, submit_zero;

   assign submit_acc  = bus.submit_valid && !fifo_full;
   assign submit_zero = (bus.submit_kernel.thread_count == '0);
   assign fifo_wr     = submit_acc && !submit_zero;
   assign fifo_rd     = |grant_vec;

   kernel_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data (saturate_tc(bus.submit_kernel)),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Retire: lowest-index RUN core with matching finish. Dispatch: round-robin over IDLE cores.
   always_comb begin
      logic found_r;
      logic found_g;
      grant_vec  = '0;
      retire_vec = '0;
      rr_d       = rr_q;
      found_r    = 1'b0;
      found_g    = 1'b0;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         if (!found_r && state_q[c] == RUN && bus.core_finished_in[c] &&
             bus.core_finished_warp_id_in[c] == kernel_q[c].warp_id) begin
            retire_vec[c] = 1'b1;
            found_r       = 1'b1;
         end
      end
      if (!fifo_empty) begin
         for (int unsigned c = 0; c < NUM_CORES; c++) begin
            if (!found_g && c >= 32'(rr_q) && state_q[c] == IDLE) begin
               grant_vec[c] = 1'b1;
               found_g      = 1'b1;
               rr_d         = (c == NUM_CORES - 1) ? '0 : RR_W'(c + 1);
            end
         end
         for (int unsigned c = 0; c < NUM_CORES; c++) begin
            if (!found_g && state_q[c] == IDLE) begin
               grant_vec[c] = 1'b1;
               found_g      = 1'b1;
               rr_d         = (c == NUM_CORES - 1) ? '0 : RR_W'(c + 1);
            end
         end
      end
   end

   // Per-core state and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned c = 0; c < NUM_CORES; c++) state_q[c] <= IDLE;
         rr_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   // Per-core next state: IDLE -> RUN on grant, RUN -> DRAIN on retire, DRAIN lasts one cycle.
   always_comb begin
      state_d = state_q;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         case (state_q[c])
            IDLE:    if (grant_vec[c])  state_d[c] = RUN;
            RUN:     if (retire_vec[c]) state_d[c] = DRAIN;
            DRAIN:   state_d[c] = IDLE;
            default: state_d[c] = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs driven by grant/retire events.
   always_comb begin
      kernel_d     = kernel_q;
      clear_d      = '0;
      done_valid_d = 1'b0;
      done_id_d    = done_id_q;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         if (grant_vec[c]) kernel_d[c] = fifo_rdata;
         if (retire_vec[c]) begin
            kernel_d[c]  = '0;
            clear_d[c]   = 1'b1;
            done_valid_d = 1'b1;
            done_id_d    = kernel_q[c].warp_id;
         end
      end
   end

   // Output registers; a zero-thread submission flags an error one cycle later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kernel_q     <= '0;
         clear_q      <= '0;
         done_valid_q <= 1'b0;
         done_id_q    <= NO_WARP;
         err_q        <= 1'b0;
      end else begin
         kernel_q     <= kernel_d;
         clear_q      <= clear_d;
         done_valid_q <= done_valid_d;
         done_id_q    <= done_id_d;
         err_q        <= submit_acc && submit_zero;
      end
   end

   // Every core parked in IDLE.
   always_comb begin
      cores_idle = 1'b1;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         if (state_q[c] != IDLE) cores_idle = 1'b0;
      end
   end

   assign bus.submit_ready    = !fifo_full;
   assign bus.core_kernel_out = kernel_q;
   assign bus.core_clear      = clear_q;
   assign bus.done_valid      = done_valid_q;
   assign bus.done_warp_id    = done_id_q;
   assign bus.err_zero        = err_q;
   assign bus.all_idle        = fifo_empty && cores_idle;

endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler with a transaction-level reference model.
module tb_warp_scheduler;
   import warp_scheduler_pkg::*;

   localparam int N  = 2;
   localparam int QD = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   warp_scheduler_if #(.NUM_CORES(N)) bus ();
   warp_scheduler #(.NUM_CORES(N), .QUEUE_DEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct { int edge_n; int core; kernel_t k; } disp_t;
   typedef struct { int edge_n; int core; logic [3:0] id; } done_t;
   typedef struct { logic ready; logic err; logic idle; kernel_t [N-1:0] kv; } cyc_t;

   disp_t   exp_disp[$];
   done_t   exp_done[$];
   cyc_t    exp_cyc[$];

   // Reference model: pending descriptors, what each core holds, when it becomes dispatchable.
   kernel_t mq[$];
   kernel_t m_desc [N];
   bit      m_busy [N];
   int      m_free [N];
   int      m_rr = 0;
   bit      m_err = 0;

   int edge_n = 0;
   int n_chk  = 0;
   int n_err  = 0;
   bit fin_req [N];
   bit rand_fin   = 0;
   bit drain_mode = 0;
   int fin_div    = 3;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic miss(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s (edge %0d)", name, edge_n);
   endtask

   function automatic kernel_t model_sat(kernel_t k);
      kernel_t r = k;
      if (int'(k.thread_count) > int'(THREAD_COUNT)) r.thread_count = TC_W'(THREAD_COUNT);
      return r;
   endfunction

   function automatic bit model_quiet();
      bit q = (mq.size() == 0);
      for (int c = 0; c < N; c++) if (m_busy[c] || m_free[c] > edge_n + 1) q = 0;
      return q;
   endfunction

   // Model update on each edge from the inputs present at that edge; pushes expectations.
   always @(posedge clk) begin
      logic sv;
      kernel_t sk;
      logic [N-1:0] fin;
      logic [N-1:0][3:0] fid;
      int win, g, pre, c;
      cyc_t cy;
      edge_n++;
      sv  = bus.submit_valid;
      sk  = bus.submit_kernel;
      fin = bus.core_finished_in;
      fid = bus.core_finished_warp_id_in;
      if (!rst) begin
         mq.delete();
         for (int i = 0; i < N; i++) begin
            m_busy[i] = 0;
            m_free[i] = 0;
            m_desc[i] = '0;
         end
         m_rr  = 0;
         m_err = 0;
      end else begin
         pre = mq.size();
         win = -1;
         for (int i = 0; i < N; i++)
            if (win < 0 && m_busy[i] && fin[i] && fid[i] == m_desc[i].warp_id) win = i;
         g = -1;
         if (pre != 0) begin
            for (int i = 0; i < N; i++) begin
               c = (m_rr + i) % N;
               if (g < 0 && !m_busy[c] && edge_n >= m_free[c]) g = c;
            end
         end
         if (win >= 0) begin
            exp_done.push_back('{edge_n, win, m_desc[win].warp_id});
            m_busy[win] = 0;
            m_free[win] = edge_n + 2;
         end
         if (g >= 0) begin
            m_desc[g] = mq.pop_front();
            m_busy[g] = 1;
            m_rr      = (g + 1) % N;
            exp_disp.push_back('{edge_n, g, m_desc[g]});
         end
         m_err = sv && pre < QD && sk.thread_count == '0;
         if (sv && pre < QD && sk.thread_count != '0) mq.push_back(model_sat(sk));
      end
      cy.ready = (mq.size() < QD);
      cy.err   = m_err;
      cy.idle  = model_quiet();
      for (int i = 0; i < N; i++) cy.kv[i] = m_busy[i] ? m_desc[i] : '0;
      exp_cyc.push_back(cy);
   end

   // Monitor: compares DUT outputs #1 after each edge against the queued expectations.
   kernel_t prev [N];
   always @(posedge clk) begin
      cyc_t cy;
      disp_t p;
      done_t d;
      kernel_t cur;
      logic [N-1:0] mask;
      #1;
      if (exp_cyc.size() == 0) miss("cycle_expectation_missing");
      else begin
         cy = exp_cyc.pop_front();
         chk("submit_ready", 64'(bus.submit_ready), 64'(cy.ready));
         chk("err_zero", 64'(bus.err_zero), 64'(cy.err));
         chk("all_idle", 64'(bus.all_idle), 64'(cy.idle));
         for (int c = 0; c < N; c++)
            chk($sformatf("kernel_out%0d", c), 64'(bus.core_kernel_out[c]), 64'(cy.kv[c]));
      end
      for (int c = 0; c < N; c++) begin
         cur = bus.core_kernel_out[c];
         if (cur.thread_count != '0 && prev[c].thread_count == '0) begin
            if (exp_disp.size() == 0) miss($sformatf("unexpected_dispatch core %0d", c));
            else begin
               p = exp_disp.pop_front();
               chk("dispatch_core", 64'(c), 64'(p.core));
               chk("dispatch_edge", 64'(edge_n), 64'(p.edge_n));
               chk("dispatch_desc", 64'(cur), 64'(p.k));
            end
         end
         prev[c] = cur;
      end
      while (exp_disp.size() > 0 && exp_disp[0].edge_n <= edge_n) begin
         void'(exp_disp.pop_front());
         miss("dispatch_missing");
      end
      if (bus.done_valid) begin
         if (exp_done.size() == 0) miss($sformatf("unexpected_done id %0h", bus.done_warp_id));
         else begin
            d = exp_done.pop_front();
            mask = '0;
            mask[d.core] = 1'b1;
            chk("done_warp_id", 64'(bus.done_warp_id), 64'(d.id));
            chk("done_edge", 64'(edge_n), 64'(d.edge_n));
            chk("core_clear", 64'(bus.core_clear), 64'(mask));
         end
      end else begin
         chk("core_clear_quiet", 64'(bus.core_clear), 64'(0));
      end
      while (exp_done.size() > 0 && exp_done[0].edge_n <= edge_n) begin
         void'(exp_done.pop_front());
         miss("done_missing");
      end
   end

   // Core emulator: raises finish for requested cores, plus stray/mismatched finishes.
   task automatic drive_cores();
      for (int c = 0; c < N; c++) begin
         if (!m_busy[c]) fin_req[c] = 0;
         else if (drain_mode || (rand_fin && $urandom_range(0, fin_div) == 0)) fin_req[c] = 1;
         if (fin_req[c]) begin
            bus.core_finished_in[c]         = 1'b1;
            bus.core_finished_warp_id_in[c] = m_desc[c].warp_id;
         end else if (rand_fin && $urandom_range(0, 7) == 0) begin
            bus.core_finished_in[c]         = 1'b1;
            bus.core_finished_warp_id_in[c] = m_busy[c] ? 4'(m_desc[c].warp_id + 1)
                                                        : 4'($urandom_range(0, 15));
         end else begin
            bus.core_finished_in[c]         = 1'b0;
            bus.core_finished_warp_id_in[c] = 4'($urandom_range(0, 15));
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.submit_valid = 1'b0;
         drive_cores();
      end
   endtask

   // Holds valid until the model says the FIFO has room; optionally releases a core while waiting.
   task automatic submit(input int id, input int pc, input int tc, input int rel_core = -1);
      kernel_t k;
      bit acc = 0;
      k.warp_id      = 4'(id);
      k.start_pc     = 32'(pc);
      k.thread_count = TC_W'(tc);
      for (int t = 0; t < 64 && !acc; t++) begin
         @(negedge clk);
         if (t == 5 && rel_core >= 0) fin_req[rel_core] = 1;
         acc = (mq.size() < QD);
         bus.submit_valid  = 1'b1;
         bus.submit_kernel = k;
         drive_cores();
      end
      if (!acc) miss($sformatf("submit_timeout warp %0d", id));
   endtask

   task automatic random_phase(input int cycles, input int rate, input int fdiv);
      kernel_t k;
      rand_fin = 1;
      fin_div  = fdiv;
      repeat (cycles) begin
         @(negedge clk);
         k.warp_id      = 4'($urandom_range(0, 15));
         k.start_pc     = $urandom();
         k.thread_count = ($urandom_range(0, 7) == 0) ? '0 : TC_W'($urandom_range(1, 15));
         bus.submit_valid  = ($urandom_range(0, 99) < rate);
         bus.submit_kernel = k;
         drive_cores();
      end
      rand_fin = 0;
   endtask

   task automatic drain();
      bit ok = 0;
      drain_mode = 1;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge clk);
         bus.submit_valid = 1'b0;
         drive_cores();
         ok = model_quiet();
      end
      drain_mode = 0;
      if (!ok) miss("drain_timeout");
      idle(2);
   endtask

   task automatic chk_reset_now(input string tag);
      for (int c = 0; c < N; c++)
         chk($sformatf("%s_kernel%0d", tag, c), 64'(bus.core_kernel_out[c]), 64'(0));
      chk({tag, "_ready"}, 64'(bus.submit_ready), 64'(1));
      chk({tag, "_all_idle"}, 64'(bus.all_idle), 64'(1));
      chk({tag, "_done_valid"}, 64'(bus.done_valid), 64'(0));
      chk({tag, "_done_id"}, 64'(bus.done_warp_id), 64'(NO_WARP));
      chk({tag, "_err"}, 64'(bus.err_zero), 64'(0));
      chk({tag, "_clear"}, 64'(bus.core_clear), 64'(0));
   endtask

   initial begin
      bus.submit_valid             = 1'b0;
      bus.submit_kernel            = '0;
      bus.core_finished_in         = '0;
      bus.core_finished_warp_id_in = '0;
      for (int c = 0; c < N; c++) fin_req[c] = 0;
      repeat (3) @(negedge clk);
      chk_reset_now("por");
      rst = 1'b1;

      // Single warp through dispatch and retire.
      submit(3, 32'h100, 4);
      idle(2);
      fin_req[0] = 1;
      idle(4);

      // Three back to back; third waits for a core.
      submit(0, 32'h200, 2);
      submit(1, 32'h210, 3);
      submit(2, 32'h220, 5);
      idle(2);
      fin_req[1] = 1;
      idle(5);
      drain();

      // Simultaneous finishes.
      submit(5, 32'h500, 1);
      submit(6, 32'h600, 7);
      idle(3);
      fin_req[0] = 1;
      fin_req[1] = 1;
      idle(5);

      // Zero-thread discard and saturation.
      submit(7, 32'h700, 0);
      submit(8, 32'h800, THREAD_COUNT + 3);
      idle(3);
      drain();

      // Fill the FIFO while both cores run; an extra waits for a freed entry.
      for (int i = 0; i < 10; i++) submit(i, 32'h1000 + i * 4, 1 + (i % 8));
      submit(10, 32'h2000, 6, 0);
      idle(2);
      drain();

      random_phase(400, 80, 3);
      random_phase(400, 30, 1);
      random_phase(400, 95, 10);
      drain();

      // Reset while cores run and the FIFO holds entries.
      for (int i = 0; i < 5; i++) submit(9 + i, 32'h3000 + i, 3);
      idle(1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_now("midrst");
      idle(2);
      rst = 1'b1;
      idle(6);

      random_phase(400, 50, 2);
      drain();
      idle(3);

      chk("exp_disp_left", 64'(exp_disp.size()), 64'(0));
      chk("exp_done_left", 64'(exp_done.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1);
   end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Queues kernel_t warp descriptors from the host and dispatches them to NUM_CORES simd_core instances, one warp per core at a time.
- Selects among idle cores round-robin, watches each core's is_finished_out/finished_warp_id, retires finished warps and re-arms the core.
- Sits between the host/testbench launch interface and the array of simd_core kernel_in ports.

Parameters:
- NUM_CORES, 2, number of simd_core instances served.
- QUEUE_DEPTH, 8, descriptor FIFO entries; power of 2, at least 2.
- THREAD_COUNT, package constant, maximum threads per warp; used to saturate thread_count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- submit_valid  in  1  host offers a descriptor.
- submit_kernel  in  kernel_t  warp_id, start_pc, thread_count.
- submit_ready  out  1  FIFO not full.
- core_kernel_out  out  kernel_t[NUM_CORES]  drives each core's kernel_in.
- core_clear  out  NUM_CORES  one-cycle pulse; resets a core's per-thread state.
- core_finished_in  in  NUM_CORES  each core's is_finished_out.
- core_finished_warp_id_in  in  4[NUM_CORES]  each core's finished_warp_id.
- done_valid  out  1  one-cycle pulse; a warp retired.
- done_warp_id  out  4  id of the retired warp.
- err_zero  out  1  one-cycle pulse; a submission with thread_count==0 was discarded.
- all_idle  out  1  FIFO empty and every core IDLE.

Behaviour:
- Reset (rst low, asynchronous). FIFO empty. All cores IDLE. Round-robin pointer = 0. core_kernel_out all zero (thread_count=0 means core inactive). core_clear=0, done_valid=0, done_warp_id=4'hF, err_zero=0, submit_ready=1, all_idle=1. Reset mid-operation abandons queued and running warps with no done reports.
- Submit handshake: a transfer occurs on a clock edge where submit_valid && submit_ready.
  - submit_ready = !full. There is no bypass when full, even if a dispatch happens in the same cycle.
  - thread_count==0: accepted, not enqueued, err_zero pulses on the next cycle.
  - thread_count>THREAD_COUNT: saturated to THREAD_COUNT when enqueued.
- Per-core FSM:
  - IDLE: no warp. On dispatch, load the descriptor into core_kernel_out[c] → RUN.
  - RUN: hold core_kernel_out[c] stable. When core_finished_in[c] && core_finished_warp_id_in[c]==core_kernel_out[c].warp_id and this core wins the retire slot → DRAIN. A mismatched warp id is ignored.
  - DRAIN (1 cycle): core_kernel_out[c] zeroed, core_clear[c]=1 → IDLE.
- Dispatch:
  - At most one per cycle.
  - Grant goes to the first IDLE core at or after the round-robin pointer, wrapping modulo NUM_CORES. The pointer then moves to grant+1.
  - Requires a non-empty FIFO.
  - A descriptor accepted on edge E can appear on core_kernel_out no earlier than edge E+1.
  - A core leaving DRAIN is not dispatchable in that same cycle; earliest re-dispatch is the cycle after it is IDLE.
- Retire:
  - At most one per cycle; the lowest-index eligible core wins.
  - Losing cores stay in RUN and retry next cycle.
  - done_valid/done_warp_id are registered and pulse on the edge the winner enters DRAIN.
- Simultaneous events: dispatch, retire and submit may all occur in one cycle. The FIFO count updates by +1, -1 or 0 accordingly.
- FIFO: read/write pointers are $clog2(QUEUE_DEPTH) bits wide and wrap; count is one bit wider. full = count==QUEUE_DEPTH, empty = count==0.
- all_idle is combinational from registered state.

Decomposition:
- Shared package (Structs_and_Params.svh): kernel_t with warp_id[3:0], start_pc[31:0], thread_count[$clog2(THREAD_COUNT+1)-1:0]; THREAD_COUNT; core state enum {IDLE, RUN, DRAIN}; NO_WARP = 4'hF.
- Sub-module: kernel_fifo, a parameterised synchronous FIFO of kernel_t with count/full/empty.
- Arbitration and per-core FSMs stay in warp_scheduler.

Test Plan:
1. Reset, then submit {warp 3, pc 0x100, tc 4} → core_kernel_out[0] = that descriptor 1 cycle after acceptance. Drive core_finished_in[0]=1 with id 3 → next edge: done_valid=1, done_warp_id=3, core_clear[0]=1, core_kernel_out[0].thread_count=0. One cycle later all_idle=1.
2. Submit warps 0, 1, 2 back to back → warp 0 on core 0, warp 1 on core 1, warp 2 held in FIFO. Retire core 1 → warp 2 dispatched to core 1 two cycles after the retire edge.
3. Fill with 8 submissions while both cores are RUN → submit_ready=0 after the 8th acceptance. A 9th held valid is accepted only after a dispatch frees an entry.
4. Both cores finish in the same cycle (ids 5 and 6) → done pulses id 5, then id 6 on consecutive cycles. Core 1 stays RUN one extra cycle.
5. Submit tc=0 → err_zero pulses once, FIFO count unchanged. Submit tc = THREAD_COUNT+3 → dispatched thread_count = THREAD_COUNT.
6. Assert rst low while cores are RUN and the FIFO holds 3 entries → all outputs at reset values immediately, with no done pulse after release.
